// File: rtl/softex_stream_job_sched.sv
// softex_stream_job_sched: queues byte-length vector jobs and programs one
// streamer transfer per job (base, beat count, stride). Tracks beat handshakes
// to drive per-beat byte strobes and last-beat flag, and pulses done per job.
// Optional feature macro: SOFTEX_JOB_SCHED_PERF_EN enables a saturating
// busy-cycle counter on perf_busy_cyc_o (tied to 0 otherwise).
module softex_stream_job_sched #(
    parameter int unsigned DW     = 256,
    parameter int unsigned QDEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [31:0]       job_base_i,
    input  logic [31:0]       job_len_i,
    output logic              strm_start_o,
    input  logic              strm_ready_i,
    output logic [31:0]       strm_base_o,
    output logic [31:0]       strm_tot_len_o,
    output logic [31:0]       strm_stride_o,
    input  logic              beat_hs_i,
    output logic [DW/8-1:0]   beat_strb_o,
    output logic              beat_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       perf_busy_cyc_o
);

    localparam int unsigned B  = DW / 8;
    localparam int unsigned L  = $clog2(B);
    localparam int unsigned QW = $clog2(QDEPTH);
    localparam logic [B-1:0] STRB_ONE = B'(1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     base_q, base_d;
    logic [31:0]     tot_q, tot_d;
    logic [31:0]     stride_q, stride_d;
    logic [L-1:0]    lft_q, lft_d;

    logic [31:0]     qb_q [QDEPTH];
    logic [31:0]     qb_d [QDEPTH];
    logic [31:0]     ql_q [QDEPTH];
    logic [31:0]     ql_d [QDEPTH];
    logic [QW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [QW:0]     qcnt_q, qcnt_d;
    logic            ready_q, ready_d;

    logic            push, pop, last;
    logic [31:0]     head_len, head_tot;
    logic [32:0]     head_sum;
    logic [B-1:0]    fin_strb;

    assign push     = job_valid_i & ready_q;
    assign pop      = (state_q == IDLE) && (qcnt_q != '0);
    assign head_len = ql_q[rd_q];
    // 33-bit sum so lengths near 2^32 round up without wrapping
    assign head_sum = {1'b0, head_len} + 33'(B - 1);
    assign head_tot = 32'(head_sum >> L);
    assign last     = (state_q == RUN) && (cnt_q == tot_q - 32'd1);

    // Queue storage, pointers and registered not-full flag
    always_comb begin
        qb_d   = qb_q;
        ql_d   = ql_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        qcnt_d = qcnt_q;
        if (push) begin
            qb_d[wr_q] = job_base_i;
            ql_d[wr_q] = job_len_i;
            wr_d       = wr_q + QW'(1);
        end
        if (pop) rd_d = rd_q + QW'(1);
        if (push && !pop)      qcnt_d = qcnt_q + (QW+1)'(1);
        else if (!push && pop) qcnt_d = qcnt_q - (QW+1)'(1);
        // QDEPTH is a power of two, so full is exactly the count MSB
        ready_d = ~qcnt_d[QW];
    end

    // Job FSM: latch head, start streamer, count beats, report done
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        tot_d        = tot_q;
        lft_d        = lft_q;
        stride_d     = stride_q;
        strm_start_o = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            IDLE: if (pop) begin
                base_d   = qb_q[rd_q];
                tot_d    = head_tot;
                lft_d    = head_len[L-1:0];
                stride_d = 32'(B);
                cnt_d    = '0;
                state_d  = (head_tot == '0) ? DONE : START;
            end
            START: if (strm_ready_i) begin
                strm_start_o = 1'b1;
                state_d      = RUN;
            end
            RUN: if (beat_hs_i) begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Final-beat strobe masks off bytes beyond the job length
    always_comb begin
        fin_strb = (lft_q == '0) ? '1 : ((STRB_ONE << lft_q) - STRB_ONE);
    end

    // State registers; clear behaves exactly like reset
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            tot_q    <= '0;
            lft_q    <= '0;
            stride_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            qcnt_q   <= '0;
            ready_q  <= 1'b1;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                qb_q[i] <= '0;
                ql_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            tot_q    <= tot_d;
            lft_q    <= lft_d;
            stride_q <= stride_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            qcnt_q   <= qcnt_d;
            ready_q  <= ready_d;
            qb_q     <= qb_d;
            ql_q     <= ql_d;
        end
    end

    assign job_ready_o    = ready_q;
    assign strm_base_o    = base_q;
    assign strm_tot_len_o = tot_q;
    assign strm_stride_o  = stride_q;
    assign beat_last_o    = last;
    assign beat_strb_o    = last ? fin_strb : '1;
    assign busy_o         = (state_q != IDLE) || (qcnt_q != '0);

`ifdef SOFTEX_JOB_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of busy cycles
    always_comb begin
        perf_d = perf_q;
        if (busy_o && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    // Perf counter register
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) perf_q <= '0;
        else                  perf_q <= perf_d;
    end

    assign perf_busy_cyc_o = perf_q;
`else
    assign perf_busy_cyc_o = '0;
`endif

endmodule
